// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// hz_entry_t describes one in-flight instruction tracked after decode.
// The dst field is sized for the widest supported register address (HZ_AW_MAX).
// Narrower addresses are zero-extended into it.
package pipe_hazard_pkg;

  localparam int HZ_AW_MAX = 8;

  typedef struct packed {
    logic                 valid;
    logic [HZ_AW_MAX-1:0] dst;
    logic                 wr;
    logic                 load;
    logic                 setflags;
  } hz_entry_t;

  localparam hz_entry_t BUBBLE = '0;

  // Width of a per-source forward select for a given tracking depth.
  function automatic int fsel_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-source hazard matcher: compares one source register against every tracked
// writer and produces the youngest forwardable position plus a load-use hit.
// The zero register and unused sources never match.
module hazard_match
  import pipe_hazard_pkg::*;
#(
  parameter  int REG_AW     = 5,
  parameter  int FWD_DEPTH  = 3,
  parameter  int LOAD_STALL = 1,
  parameter  int ZERO_REG   = 31,
  localparam int FSW        = fsel_w(FWD_DEPTH)
) (
  input  hz_entry_t [FWD_DEPTH-1:0] entries,
  input  logic [REG_AW-1:0]         src,
  input  logic                      used,
  output logic [FSW-1:0]            sel,
  output logic                      load_hit
);

  logic                 src_ok;
  logic [FWD_DEPTH-1:0] hit;

  assign src_ok = used && (src != REG_AW'(ZERO_REG));

  // Per-position match of this source against live writers.
  always_comb begin
    hit = '0;
    for (int i = 0; i < FWD_DEPTH; i++) begin
      hit[i] = src_ok && entries[i].valid && entries[i].wr &&
               (entries[i].dst == HZ_AW_MAX'(src));
    end
  end

  // Youngest match wins: scan oldest-to-youngest so the lowest index is written last.
  // The oldest position is excluded because its write has already reached the regfile.
  always_comb begin
    sel = '0;
    for (int i = FWD_DEPTH - 2; i >= 0; i--) begin
      if (hit[i]) sel = FSW'(i + 1);
    end
  end

  // A load too close to the consumer to forward forces a stall.
  always_comb begin
    load_hit = 1'b0;
    for (int i = 0; i < LOAD_STALL; i++) begin
      if (hit[i] && entries[i].load) load_hit = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the in-order 5-stage pipeline.
// Tracks writers in a FWD_DEPTH-deep shift register (entry0 = EX), raises load-use
// stalls, registers per-source forward selects into EX and drives the flag bypass.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall/forward counters.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter  int REG_AW     = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int FWD_DEPTH  = 3,
  parameter  int LOAD_STALL = 1,
  parameter  int ZERO_REG   = 31,
  localparam int FSW        = fsel_w(FWD_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_wr,
  input  logic                      id_load,
  input  logic                      id_setflags,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*FSW-1:0]    ex_fwd_sel,
  output logic                      flags_fwd
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]               perf_stalls,
  output logic [31:0]               perf_fwds
`endif
);

  hz_entry_t [FWD_DEPTH-1:0] entries;
  hz_entry_t                 entry_new;
  logic [NUM_SRC*FSW-1:0]    sel_next;
  logic [NUM_SRC-1:0]        load_hits;
  logic                      issue;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hazard_match #(
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_STALL(LOAD_STALL),
      .ZERO_REG  (ZERO_REG)
    ) u_match (
      .entries (entries),
      .src     (id_src[s*REG_AW +: REG_AW]),
      .used    (id_src_used[s]),
      .sel     (sel_next[s*FSW +: FSW]),
      .load_hit(load_hits[s])
    );
  end

  // Flush dominates: a squashed instruction never stalls the front end.
  assign stall     = id_valid & ~flush & (|load_hits);
  assign issue     = id_valid & ~stall & ~flush;
  assign flags_fwd = entries[0].valid & entries[0].setflags;

  // New EX entry: the issuing instruction, or a bubble on stall/flush/idle.
  always_comb begin
    entry_new = BUBBLE;
    if (issue) begin
      entry_new.valid    = 1'b1;
      entry_new.dst      = HZ_AW_MAX'(id_dst);
      entry_new.wr       = id_wr;
      entry_new.load     = id_load;
      entry_new.setflags = id_setflags;
    end
  end

  // Writer tracking shift register; the oldest entry falls off the end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) entries <= '0;
    else        entries <= {entries[FWD_DEPTH-2:0], entry_new};
  end

  // Forward selects travel with the instruction into EX; bubbles carry zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ex_fwd_sel <= '0;
    else        ex_fwd_sel <= issue ? sel_next : '0;
  end

`ifdef HAZARD_PERF_EN
  // Saturating event counters for stall cycles and forwarded issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stalls <= '0;
      perf_fwds   <= '0;
    end else begin
      if (stall && (perf_stalls != '1)) perf_stalls <= perf_stalls + 32'd1;
      if (issue && (|sel_next) && (perf_fwds != '1)) perf_fwds <= perf_fwds + 32'd1;
    end
  end
`endif

endmodule
